// File: rtl/aes_uart_pkg.sv
// Shared constants and the block sender state encoding for the AES-to-UART path.
package aes_uart_pkg;

   // Width of one serial byte and number of bytes in one AES-128 block
   localparam int unsigned AES_DATA_WIDTH  = 8;
   localparam int unsigned AES_BLOCK_BYTES = 16;
   // Byte counter width, enough to index AES_BLOCK_BYTES bytes
   localparam int unsigned AES_CNT_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_DRIVE     = 2'd2,
      ST_WAIT_DONE = 2'd3
   } sender_state_e;

endpackage : aes_uart_pkg

// File: rtl/uart_block_sender.sv
// Serialises one ciphertext block into bytes for a UART transmitter, most
// significant byte first, and pulses block_sent once the last byte has left.
//
// Ports:
//   clk, reset_n   sole clock, synchronous active-low reset
//   block_valid    upstream block available on block_data
//   block_data     ciphertext block, byte k = block_data[8k+7:8k]
//   block_ready    high in IDLE only; block taken on block_valid && block_ready
//   tx_drive       one-cycle start request to the transmitter
//   tx_byte_in     byte presented to the transmitter, held until its tx_done
//   tx_active      transmitter busy flag, observed only
//   tx_done        transmitter end-of-stop-bit pulse
//   busy           high from block acceptance until the last byte's tx_done
//   block_sent     one-cycle pulse when the whole block has been transmitted
module uart_block_sender
   import aes_uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = AES_DATA_WIDTH,
   parameter int unsigned BLOCK_BYTES = AES_BLOCK_BYTES
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              block_valid,
   input  logic [BLOCK_BYTES*DATA_WIDTH-1:0] block_data,
   output logic                              block_ready,
   output logic                              tx_drive,
   output logic [DATA_WIDTH-1:0]             tx_byte_in,
   input  logic                              tx_active,
   input  logic                              tx_done,
   output logic                              busy,
   output logic                              block_sent
);

   localparam int unsigned BLOCK_W = BLOCK_BYTES * DATA_WIDTH;
   localparam logic [AES_CNT_W-1:0] LAST_IDX = AES_CNT_W'(BLOCK_BYTES - 1);

   sender_state_e          state_q;
   logic [BLOCK_W-1:0]     shift_q;
   logic [AES_CNT_W-1:0]   cnt_q;
   logic [DATA_WIDTH-1:0]  byte_q;
   logic                   drive_q;
   logic                   sent_q;
   logic                   ready_q;
   logic                   busy_q;

   // The transmitter's busy flag is only observed; sequencing relies on tx_done.
   logic unused_tx_active;
   assign unused_tx_active = tx_active;

   // Sequencer: each state's action lands on the edge that leaves the state,
   // so every output is a flop and tx_drive trails acceptance/tx_done by 2.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         byte_q  <= '0;
         drive_q <= 1'b0;
         sent_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         drive_q <= 1'b0;
         sent_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (block_valid) begin
                  shift_q <= block_data;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               byte_q  <= shift_q[BLOCK_W-1 -: DATA_WIDTH];
               state_q <= ST_DRIVE;
            end
            ST_DRIVE: begin
               drive_q <= 1'b1;
               state_q <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (tx_done) begin
                  shift_q <= shift_q << DATA_WIDTH;
                  if (cnt_q == LAST_IDX) begin
                     // Counter parks on the last index; cleared on next accept.
                     sent_q  <= 1'b1;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     cnt_q   <= cnt_q + 1'b1;
                     state_q <= ST_LOAD;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign block_ready = ready_q;
   assign tx_drive    = drive_q;
   assign tx_byte_in  = byte_q;
   assign busy        = busy_q;
   assign block_sent  = sent_q;

endmodule : uart_block_sender

// File: tb/tb_uart_block_sender.sv
// Self-checking bench for uart_block_sender: a stub transmitter answers each
// tx_drive with a tx_done after a (random or fixed) delay, and a byte-order
// model derived from the block value predicts every byte and pulse.
module tb_uart_block_sender;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         block_valid;
   logic [127:0] block_data;
   logic         block_ready;
   logic         tx_drive;
   logic [7:0]   tx_byte_in;
   logic         tx_active;
   logic         tx_done;
   logic         busy;
   logic         block_sent;

   int n_checks = 0;
   int n_errors = 0;
   int sent_seen = 0;
   int exp_blocks = 0;

   uart_block_sender dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .block_valid (block_valid),
      .block_data  (block_data),
      .block_ready (block_ready),
      .tx_drive    (tx_drive),
      .tx_byte_in  (tx_byte_in),
      .tx_active   (tx_active),
      .tx_done     (tx_done),
      .busy        (busy),
      .block_sent  (block_sent)
   );

   always #5 clk = ~clk;

   // Independent count of block_sent pulses over the whole run
   always @(negedge clk) begin
      if (block_sent === 1'b1) sent_seen++;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rand_block();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Sends one block through the stub transmitter and checks every cycle.
   //   hold        keep block_valid high throughout, presenting next_data
   //   fixed_dly   cycles between seeing tx_drive and raising tx_done (-1 = random)
   //   abort_after apply reset right after this many tx_done pulses (0 = never)
   //   spur        randomly inject tx_done while the sender is loading/driving
   task automatic send_block(input logic [127:0] data, input bit hold,
                             input logic [127:0] next_data, input int fixed_dly,
                             input int abort_after, input bit spur);
      logic [7:0] exp_q[$];
      logic [7:0] exp_b;
      int waited;
      int dly;
      // Bytes leave most significant first: byte 15 down to byte 0
      for (int k = 15; k >= 0; k--) exp_q.push_back(data[8*k +: 8]);

      waited = 0;
      while (block_ready !== 1'b1 && waited < 50) begin
         step();
         waited++;
      end
      check("accept_ready", block_ready, 1);
      block_data  = data;
      block_valid = 1'b1;
      step();
      if (hold) block_data = next_data;
      else      block_valid = 1'b0;
      check("busy_after_accept", busy, 1);
      check("ready_after_accept", block_ready, 0);
      check("sent_single", block_sent, 0);

      for (int i = 0; i < 16; i++) begin
         exp_b = exp_q.pop_front();
         tx_done = spur && ($urandom_range(0, 1) == 1);
         step();
         check("drive_early", tx_drive, 0);
         tx_done = spur && ($urandom_range(0, 1) == 1);
         step();
         tx_done = 1'b0;
         check("drive_pulse", tx_drive, 1);
         check("byte_value", tx_byte_in, exp_b);
         tx_active = 1'b1;
         dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 12));
         for (int c = 0; c < dly; c++) begin
            step();
            check("drive_single", tx_drive, 0);
            check("byte_stable", tx_byte_in, exp_b);
            check("busy_wait", busy, 1);
            if (hold) check("ready_held_low", block_ready, 0);
         end
         tx_done = 1'b1;
         step();
         tx_done   = 1'b0;
         tx_active = 1'b0;
         if (abort_after == i + 1) begin
            reset_n = 1'b0;
            step();
            reset_n = 1'b1;
            check("abort_drive", tx_drive, 0);
            check("abort_byte", tx_byte_in, 0);
            check("abort_sent", block_sent, 0);
            check("abort_busy", busy, 0);
            check("abort_ready", block_ready, 1);
            for (int c = 0; c < 3; c++) begin
               step();
               check("abort_no_sent", block_sent, 0);
               check("abort_no_drive", tx_drive, 0);
            end
            return;
         end
         if (i == 15) begin
            exp_blocks++;
            check("sent_pulse", block_sent, 1);
            check("busy_end", busy, 0);
            check("ready_end", block_ready, 1);
         end else begin
            check("sent_early", block_sent, 0);
            check("busy_mid", busy, 1);
         end
      end
   endtask

   initial begin
      logic [127:0] b3;
      reset_n     = 1'b0;
      block_valid = 1'b0;
      block_data  = '0;
      tx_active   = 1'b0;
      tx_done     = 1'b0;
      repeat (3) step();
      check("rst_ready", block_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_drive", tx_drive, 0);
      check("rst_sent", block_sent, 0);
      check("rst_byte", tx_byte_in, 0);
      reset_n = 1'b1;
      step();

      // Spurious tx_done while idle must change nothing
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      step();
      check("idle_spur_ready", block_ready, 1);
      check("idle_spur_busy", busy, 0);
      check("idle_spur_drive", tx_drive, 0);
      check("idle_spur_sent", block_sent, 0);
      check("idle_spur_byte", tx_byte_in, 0);

      // Known block with a 10-cycle stub transmitter
      send_block(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0, '0, 9, 0, 1'b0);
      step();
      check("after_known_sent", block_sent, 0);

      // Valid held high for a whole block; the follow-on block waits
      b3 = rand_block();
      send_block(rand_block(), 1'b1, b3, -1, 0, 1'b1);
      send_block(b3, 1'b0, '0, -1, 0, 1'b1);
      step();

      // Reset after the 5th byte, then a fresh block restarts from byte 15
      send_block(rand_block(), 1'b0, '0, -1, 5, 1'b0);
      send_block(128'hA5000000_00000000_00000000_0000005A, 1'b0, '0, 0, 0, 1'b1);
      step();

      for (int n = 0; n < 4; n++) begin
         send_block(rand_block(), 1'b0, '0, -1, 0, 1'b1);
         repeat ($urandom_range(0, 3)) step();
      end

      repeat (3) step();
      check("sent_count", sent_seen, exp_blocks);
      check("final_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_uart_block_sender
